// File: rtl/divider_seq_restoring.sv
// Unsigned sequential restoring divider: one quotient bit per clock, start/done handshake.
// Produces Q = A / B and R = A % B; a zero divisor finishes at once with div_by_zero set.
module divider_seq_restoring #(
    parameter int bw = 8
) (
    input  logic          CLK,
    input  logic          RESET,
    input  logic          start,
    input  logic [bw-1:0] A,
    input  logic [bw-1:0] B,
    output logic          busy,
    output logic          done,
    output logic [bw-1:0] Q,
    output logic [bw-1:0] R,
    output logic          div_by_zero
);

    localparam int CW = $clog2(bw + 1);
    localparam logic [CW-1:0] LAST_COUNT = CW'(bw - 1);

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_t;

    state_t state;
    state_t state_next;

    logic [bw-1:0] rem;
    logic [bw-1:0] quo;
    logic [bw-1:0] divisor;
    logic [CW-1:0] count;

    logic [bw:0]   rem_shifted;
    logic [bw:0]   trial;
    logic          trial_ok;
    logic [bw-1:0] rem_step;
    logic [bw-1:0] quo_step;
    logic          accept;
    logic          last_step;

    // The stored remainder stays below the divisor, so bw bits hold it; the shifted
    // value needs the extra bit, and the top bit of the trial difference is the borrow.
    always_comb begin
        rem_shifted = {rem, quo[bw-1]};
        trial       = rem_shifted - {1'b0, divisor};
        trial_ok    = ~trial[bw];
        rem_step    = trial_ok ? trial[bw-1:0] : rem_shifted[bw-1:0];
        quo_step    = {quo[bw-2:0], trial_ok};
        last_step   = (count == LAST_COUNT);
    end

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        busy       = 1'b0;
        done       = 1'b0;
        accept     = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    accept     = 1'b1;
                    state_next = (B == '0) ? DONE : RUN;
                end
            end
            RUN: begin
                busy = 1'b1;
                if (last_step) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                done       = 1'b1;
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Results are only written on the accept edge of a zero divide or the final
    // iteration edge, so they hold steady for the whole of the next division.
    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            rem         <= '0;
            quo         <= '0;
            divisor     <= '0;
            count       <= '0;
            Q           <= '0;
            R           <= '0;
            div_by_zero <= 1'b0;
        end else if (accept) begin
            quo     <= A;
            divisor <= B;
            rem     <= '0;
            count   <= '0;
            if (B == '0) begin
                Q           <= '1;
                R           <= A;
                div_by_zero <= 1'b1;
            end
        end else if (state == RUN) begin
            rem   <= rem_step;
            quo   <= quo_step;
            count <= count + CW'(1);
            if (last_step) begin
                Q           <= quo_step;
                R           <= rem_step;
                div_by_zero <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_divider_seq_restoring.sv
// Bench for divider_seq_restoring: directed corners plus random operands, checked
// against plain integer division and modulo.
module tb_divider_seq_restoring;

    localparam int BW = 8;

    logic          CLK;
    logic          RESET;
    logic          start;
    logic [BW-1:0] A;
    logic [BW-1:0] B;
    logic          busy;
    logic          done;
    logic [BW-1:0] Q;
    logic [BW-1:0] R;
    logic          div_by_zero;

    int check_count = 0;
    int pass_count  = 0;

    logic [BW-1:0] prev_q   = '0;
    logic [BW-1:0] prev_r   = '0;
    logic          prev_dbz = 1'b0;

    divider_seq_restoring #(.bw(BW)) dut (
        .CLK(CLK),
        .RESET(RESET),
        .start(start),
        .A(A),
        .B(B),
        .busy(busy),
        .done(done),
        .Q(Q),
        .R(R),
        .div_by_zero(div_by_zero)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed === expected) begin
            pass_count++;
        end else begin
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [BW-1:0] a, input logic [BW-1:0] b);
        A     = a;
        B     = b;
        start = 1'b1;
    endtask

    // Called while start is raised in IDLE; the next rising edge is the accept edge.
    // With hold set, start stays high and the operand pins churn throughout the run.
    task automatic expectResult(input logic [BW-1:0] a, input logic [BW-1:0] b, input bit hold);
        logic [BW-1:0] exp_q;
        logic [BW-1:0] exp_r;
        logic          exp_dbz;
        int            exp_lat;
        int            edges;
        int            busy_cnt;
        if (b == 0) begin
            exp_q   = '1;
            exp_r   = a;
            exp_dbz = 1'b1;
            exp_lat = 0;
        end else begin
            exp_q   = a / b;
            exp_r   = a % b;
            exp_dbz = 1'b0;
            exp_lat = BW;
        end
        edges    = 0;
        busy_cnt = 0;
        @(posedge CLK);
        #1;
        if (!hold) start = 1'b0;
        while (!done && edges < 4 * BW) begin
            if (busy) busy_cnt++;
            if (edges == BW / 2) begin
                checkOutput("result_held", {Q, R, div_by_zero}, {prev_q, prev_r, prev_dbz});
            end
            if (hold) begin
                A = BW'($urandom);
                B = BW'($urandom);
            end
            @(posedge CLK);
            #1;
            edges++;
        end
        checkOutput("latency", edges, exp_lat);
        checkOutput("busy_cycles", busy_cnt, exp_lat);
        checkOutput("busy_at_done", busy, 0);
        checkOutput("quotient", Q, exp_q);
        checkOutput("remainder", R, exp_r);
        checkOutput("div_by_zero", div_by_zero, exp_dbz);
        prev_q   = exp_q;
        prev_r   = exp_r;
        prev_dbz = exp_dbz;
        if (!hold) begin
            @(posedge CLK);
            #1;
            checkOutput("done_width", done, 0);
        end
    endtask

    initial begin
        logic [BW-1:0] corner [7];
        logic [BW-1:0] pair_a [4];
        logic [BW-1:0] pair_b [4];
        logic [BW-1:0] ra;
        logic [BW-1:0] rb;
        bit            seen_done;

        corner = '{8'd0, 8'd1, 8'd2, 8'd127, 8'd128, 8'd254, 8'd255};
        pair_a = '{8'd255, 8'd5, 8'd0, 8'd200};
        pair_b = '{8'd1, 8'd9, 8'd3, 8'd200};

        RESET = 1'b1;
        start = 1'b0;
        A     = '0;
        B     = '0;
        repeat (3) @(posedge CLK);
        #1;
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_done", done, 0);
        checkOutput("reset_q", Q, 0);
        checkOutput("reset_r", R, 0);
        checkOutput("reset_dbz", div_by_zero, 0);
        RESET = 1'b0;
        @(posedge CLK);
        #1;

        $display("[TB] basic division 100/7");
        applyStimulus(8'd100, 8'd7);
        expectResult(8'd100, 8'd7, 1'b0);

        $display("[TB] directed boundary operands");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(pair_a[i], pair_b[i]);
            expectResult(pair_a[i], pair_b[i], 1'b0);
        end

        $display("[TB] divide by zero");
        applyStimulus(8'd42, 8'd0);
        expectResult(8'd42, 8'd0, 1'b0);

        $display("[TB] start held through run and done");
        applyStimulus(8'd200, 8'd9);
        expectResult(8'd200, 8'd9, 1'b1);
        applyStimulus(8'd77, 8'd5);
        @(posedge CLK);
        #1;
        checkOutput("start_in_done_ignored", {busy, done}, 0);
        expectResult(8'd77, 8'd5, 1'b0);

        $display("[TB] reset in the middle of a division");
        applyStimulus(8'd100, 8'd7);
        @(posedge CLK);
        #1;
        start = 1'b0;
        repeat (4) @(posedge CLK);
        #1;
        RESET = 1'b1;
        #1;
        checkOutput("midrun_reset_busy", busy, 0);
        checkOutput("midrun_reset_done", done, 0);
        checkOutput("midrun_reset_q", Q, 0);
        checkOutput("midrun_reset_r", R, 0);
        checkOutput("midrun_reset_dbz", div_by_zero, 0);
        @(posedge CLK);
        #1;
        RESET    = 1'b0;
        prev_q   = '0;
        prev_r   = '0;
        prev_dbz = 1'b0;
        seen_done = 1'b0;
        repeat (2 * BW) begin
            @(posedge CLK);
            #1;
            if (done || busy) seen_done = 1'b1;
        end
        checkOutput("no_activity_after_reset", seen_done, 0);
        applyStimulus(8'd100, 8'd7);
        expectResult(8'd100, 8'd7, 1'b0);

        $display("[TB] corner operand sweep");
        for (int i = 0; i < 7; i++) begin
            applyStimulus(corner[i], 8'd0);
            expectResult(corner[i], 8'd0, 1'b0);
            for (int j = 0; j < 7; j++) begin
                if (corner[j] != 0) begin
                    applyStimulus(corner[i], corner[j]);
                    expectResult(corner[i], corner[j], 1'b0);
                end
            end
        end

        $display("[TB] random operands");
        for (int n = 0; n < 1500; n++) begin
            ra = BW'($urandom);
            rb = ($urandom_range(0, 15) == 0) ? BW'(0) : BW'($urandom);
            applyStimulus(ra, rb);
            expectResult(ra, rb, 1'b0);
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule
